// File: rtl/leitor_entrada.sv
// -----------------------------------------------------------------------------
// leitor_entrada
//
// Input side of the battleship-style game that feeds the 4-digit 7-segment
// display driver. Three raw active-low push-buttons are synchronised,
// debounced and turned into single-cycle press events. Those events drive a
// small FSM that selects a map, confirms it, and in attack mode moves the
// target cursor and fires shots.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   btnA         raw button (active-low): next map / next column
//   btnB         raw button (active-low): next line (attack only)
//   btnConfirma  raw button (active-low): confirm map / fire
//   ATAQUE       mode level from game control: attack
//   PREPARACAO   mode level from game control: preparation
//   DESLIGADO    mode level from game control: off (highest priority)
//   coordColuna  selected column, 0..COORD_MAX
//   coordLinha   selected line,   0..COORD_MAX
//   mapa         selected map,    0..MAPA_MAX
//   mapaPronto   map confirmed
//   disparo      one-cycle fire pulse
//   tiros        shots fired, saturating at 15
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synchronised level must persist to be accepted
//   COORD_MAX        highest column/line value (<= 7)
//   MAPA_MAX         highest map index (<= 7)
// -----------------------------------------------------------------------------
module leitor_entrada #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COORD_MAX       = 4,
  parameter int MAPA_MAX        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnA,
  input  logic       btnB,
  input  logic       btnConfirma,
  input  logic       ATAQUE,
  input  logic       PREPARACAO,
  input  logic       DESLIGADO,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic [2:0] mapa,
  output logic       mapaPronto,
  output logic       disparo,
  output logic [3:0] tiros
);

  // The counter only ever holds 0..DEBOUNCE_CYCLES-1: the cycle in which it
  // would reach DEBOUNCE_CYCLES is the cycle the stable level flips.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] COORD_TOP = 3'(COORD_MAX);
  localparam logic [2:0] MAPA_TOP  = 3'(MAPA_MAX);
  localparam logic [3:0] TIROS_TOP = 4'd15;

  localparam int N_BTN = 3;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-FF synchroniser + debouncer + press-edge detector.
  // Bit order everywhere: [0]=A, [1]=B, [2]=Confirma.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] press;

  assign raw = {btnConfirma, btnB, btnA};

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          // Released (high) everywhere so nothing looks like a press right
          // after reset; any partial count is thrown away.
          sync1_reg  <= 1'b1;
          sync2_reg  <= 1'b1;
          stable_reg <= 1'b1;
          press_reg  <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            // Level held long enough: accept it. Only the released->pressed
            // direction produces an event; releases are silent.
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
            press_reg  <= ~sync2_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic ev_a;
  logic ev_b;
  logic ev_c;

  assign ev_a = press[BTN_A];
  assign ev_b = press[BTN_B];
  assign ev_c = press[BTN_C];

  // ---------------------------------------------------------------------------
  // Effective mode: DESLIGADO beats ATAQUE beats PREPARACAO. When none is
  // asserted every register simply holds.
  // ---------------------------------------------------------------------------
  logic mode_off;
  logic mode_atk;
  logic mode_prep;

  assign mode_off  = DESLIGADO;
  assign mode_atk  = !DESLIGADO && ATAQUE;
  assign mode_prep = !DESLIGADO && !ATAQUE && PREPARACAO;

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ESPERA_MAPA,
    MAPA_OK,
    ATAQUE_ATIVO
  } estado_t;

  estado_t    state_reg,  state_next;
  logic [2:0] col_reg,    col_next;
  logic [2:0] line_reg,   line_next;
  logic [2:0] mapa_reg,   mapa_next;
  logic       pronto_reg, pronto_next;
  logic [3:0] tiros_reg,  tiros_next;
  logic       fire;

  // ">=" rather than "==" keeps the value in range even if it ever were not.
  function automatic logic [2:0] inc_wrap(input logic [2:0] v, input logic [2:0] top);
    return (v >= top) ? 3'd0 : v + 3'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= ESPERA_MAPA;
      col_reg    <= '0;
      line_reg   <= '0;
      mapa_reg   <= '0;
      pronto_reg <= 1'b0;
      tiros_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      col_reg    <= col_next;
      line_reg   <= line_next;
      mapa_reg   <= mapa_next;
      pronto_reg <= pronto_next;
      tiros_reg  <= tiros_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    col_next    = col_reg;
    line_next   = line_reg;
    mapa_next   = mapa_reg;
    pronto_next = pronto_reg;
    tiros_next  = tiros_reg;
    fire        = 1'b0;

    if (mode_off) begin
      // Power-off wipes the game; debouncers keep running but their events
      // are simply not consumed here.
      state_next  = ESPERA_MAPA;
      col_next    = '0;
      line_next   = '0;
      mapa_next   = '0;
      pronto_next = 1'b0;
      tiros_next  = '0;
    end else if (mode_atk) begin
      case (state_reg)
        ESPERA_MAPA: begin
          // No attack without a confirmed map: all events ignored.
        end
        MAPA_OK: begin
          // Entry cycle into attack; events seen here are dropped.
          state_next = ATAQUE_ATIVO;
        end
        ATAQUE_ATIVO: begin
          // A, B and Confirma are independent and may coincide. The fire
          // pulse is combinational from the event so it is seen alongside
          // the coordinates that were current before this cycle's moves.
          if (ev_a) col_next  = inc_wrap(col_reg, COORD_TOP);
          if (ev_b) line_next = inc_wrap(line_reg, COORD_TOP);
          if (ev_c) begin
            fire       = 1'b1;
            tiros_next = (tiros_reg == TIROS_TOP) ? tiros_reg : tiros_reg + 4'd1;
          end
        end
        default: state_next = ESPERA_MAPA;
      endcase
    end else if (mode_prep) begin
      case (state_reg)
        ESPERA_MAPA: begin
          if (ev_a) mapa_next = inc_wrap(mapa_reg, MAPA_TOP);
          if (ev_c) begin
            pronto_next = 1'b1;
            state_next  = MAPA_OK;
          end
        end
        MAPA_OK: begin
          // Changing the map after confirming it withdraws the confirmation.
          if (ev_a) begin
            mapa_next   = inc_wrap(mapa_reg, MAPA_TOP);
            pronto_next = 1'b0;
            state_next  = ESPERA_MAPA;
          end
        end
        ATAQUE_ATIVO: begin
          // Leaving attack keeps coordinates and shot count.
          state_next = MAPA_OK;
        end
        default: state_next = ESPERA_MAPA;
      endcase
    end
  end

  assign coordColuna = col_reg;
  assign coordLinha  = line_reg;
  assign mapa        = mapa_reg;
  assign mapaPronto  = pronto_reg;
  assign tiros       = tiros_reg;
  assign disparo     = fire;

endmodule
